legv8_mem_arbiter: RTL and testbench
====================================

// Module: legv8_mem_arbiter
// PURPOSE
//  Shares one single-port memory between the LEGv8 instruction-fetch port (IF) and the data port (DM).
//  DM serves STUR/LDUR.
//  Sequences each access as a request/ready transaction on the memory side and a req/ack handshake per requester.
//  Arbitration is round-robin.
//  Sits between the fetch/execute logic driven by ControlUnit_LEGv8 and the unified memory model.
// PARAMETERS
//  ADDR_WIDTH      64   byte address width, all ports
//  DATA_WIDTH      64   memory/data word width; IF uses rdata[31:0] as the instruction
//  TIMEOUT_CYCLES  16   cycles in BUSY before abort; used only with LEGV8_ARB_TIMEOUT_EN
// PORTS
//  clock      in   1           rising-edge clock
//  reset      in   1           synchronous, active-high
//  if_req     in   1           fetch request; held until if_ack
//  if_addr    in   ADDR_WIDTH  fetch address
//  if_rdata   out  DATA_WIDTH  fetched word, valid while if_ack=1
//  if_ack     out  1           one-cycle fetch completion pulse
//  dm_req     in   1           data request; held until dm_ack
//  dm_we      in   1           1=store, 0=load
//  dm_addr    in   ADDR_WIDTH  data address
//  dm_wdata   in   DATA_WIDTH  store data
//  dm_rdata   out  DATA_WIDTH  load data, valid while dm_ack=1
//  dm_ack     out  1           one-cycle data completion pulse
//  mem_req    out  1           memory access in progress
//  mem_we     out  1           write strobe, qualified by mem_req
//  mem_addr   out  ADDR_WIDTH  registered access address
//  mem_wdata  out  DATA_WIDTH  registered write data
//  mem_rdata  in   DATA_WIDTH  read data, valid with mem_ready
//  mem_ready  in   1           memory completes the access this cycle
//  err        out  1           timeout abort flag, valid with either ack
// BEHAVIOUR
//  Reset (sync, 1 edge):
//  - state=IDLE; all outputs 0; last=DM, so IF wins the first tie.
//  - An access in flight is dropped; mem_req=0 after that edge, no ack issued.
//  FSM, 3 states:
//  - IDLE: samples if_req/dm_req.
//    - One request: grant it.
//    - Both: grant the port != last.
//    - On grant: latch addr/we/wdata into mem_* (IF forces mem_we=0, mem_wdata=0); set mem_req=1; update last; ->BUSY.
//    - No request: stay in IDLE.
//  - BUSY: mem_* held constant.
//    - mem_ready=1 at the edge: mem_req->0; if read, capture mem_rdata into granted rdata reg; granted ack->1; ->RESP.
//  - RESP: ack high exactly this one cycle; requests ignored; ->IDLE.
//  Requester handshake:
//  - Deasserts req, or presents a new transaction, on the edge at which it samples ack=1.
//  - req still high in IDLE is a new request.
//  Timing:
//  - Min latency req->ack = 3 cycles when mem_ready is high in the first BUSY cycle.
//  - Back-to-back throughput: 1 access per 3 cycles.
//  Data rules:
//  - dm_rdata changes only on DM loads; if_rdata only on fetches; both hold their value otherwise.
//  - Stores leave dm_rdata unchanged.
//  - Ungranted requester waits with ack=0; no starvation: alternates under continuous contention.
//  - mem_ready outside BUSY is ignored.
//  - err=0 unless timeout aborts.
// CONFIGURATION
//  LEGV8_ARB_TIMEOUT_EN defined:
//  - BUSY counter starts at 0 on entry and increments each cycle without mem_ready.
//  - At count==TIMEOUT_CYCLES-1 without mem_ready: mem_req->0; granted ack->1; err->1; granted rdata->0; ->RESP.
//  - err clears in IDLE.
//  LEGV8_ARB_TIMEOUT_EN undefined:
//  - No counter; BUSY waits indefinitely; err tied 0.
// TESTING
//  1. reset 2 cycles; IF read 0x0 with mem_ready next cycle, mem_rdata=0x91000000 -> mem_req high 1 cycle; if_ack 3 cycles after req; if_rdata=0x91000000.
//  2. DM store addr=0x40, wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; dm_ack pulse; dm_rdata unchanged.
//  3. if_req and dm_req both held, 4 transactions -> grants IF,DM,IF,DM after reset; never two consecutive grants to one port.
//  4. mem_ready delayed 5 cycles -> mem_* stable 5 cycles; ack exactly 1 cycle after the ready edge; single pulse.
//  5. reset asserted in BUSY -> next cycle mem_req=0, no ack; a following IF request proceeds normally.
//  6. TIMEOUT_EN, mem_ready never high -> ack and err=1 after 16 BUSY cycles; rdata=0; err=0 in next IDLE.

Source files
------------

// File: rtl/legv8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// legv8_mem_arbiter
//   Shares one single-port memory between the LEGv8 instruction-fetch port (IF)
//   and the data port (DM, serving STUR/LDUR). Each access is a req/ack
//   handshake on the requester side and a mem_req/mem_ready transaction on the
//   memory side. Contention is resolved round-robin: the port that was not
//   granted last wins a tie.
//
//   Optional feature macro: LEGV8_ARB_TIMEOUT_EN
//     defined   : an access stuck in BUSY for TIMEOUT_CYCLES cycles is aborted,
//                 acked with err=1 and read data forced to 0.
//     undefined : BUSY waits indefinitely for mem_ready; err is tied 0.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   if_req/if_addr         fetch request (held until if_ack) and byte address
//   if_rdata/if_ack        fetched word (valid with ack) and 1-cycle ack pulse
//   dm_req/dm_we           data request (held until dm_ack), 1=store 0=load
//   dm_addr/dm_wdata       data address and store data
//   dm_rdata/dm_ack        load data (valid with ack) and 1-cycle ack pulse
//   mem_req/mem_we         access in progress, write strobe (qualified by req)
//   mem_addr/mem_wdata     registered access address / write data
//   mem_rdata/mem_ready    read data and completion strobe from memory
//   err                    timeout-abort flag, valid with either ack
// -----------------------------------------------------------------------------
module legv8_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_dm_q, last_dm_d;   // 1: DM was granted last
  logic                  gnt_dm_q, gnt_dm_d;     // owner of the current access
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic                  pick_dm;

`ifdef LEGV8_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
`endif

  // DM wins only if IF is idle, or both request and IF was served last.
  assign pick_dm = dm_req & (~if_req | ~last_dm_q);

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    gnt_dm_d    = gnt_dm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
`ifdef LEGV8_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          gnt_dm_d  = pick_dm;
          last_dm_d = pick_dm;
          mem_req_d = 1'b1;
          if (pick_dm) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
`ifdef LEGV8_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (gnt_dm_q) dm_rdata_d = mem_rdata;
            else          if_rdata_d = mem_rdata;
          end
          if (gnt_dm_q) dm_ack_d = 1'b1;
          else          if_ack_d = 1'b1;
          state_d = S_RESP;
        end
`ifdef LEGV8_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (gnt_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        // Ack is high for this cycle only; requests are looked at again in IDLE.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_dm_q   <= 1'b1;
      gnt_dm_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
`ifdef LEGV8_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      gnt_dm_q    <= gnt_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
`ifdef LEGV8_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;

`ifdef LEGV8_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
  // TIMEOUT_CYCLES has no effect without the timeout feature.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
module tb_legv8_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          err;

  legv8_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- memory responder ----------------
  // Read data is a fixed pattern XOR address, so different accesses return
  // distinguishable words. ready_delay<0 means the memory never answers.
  logic [DW-1:0] rd_val = 64'h0000_0000_9100_0000;
  int            ready_delay = 0;
  bit            spur = 1'b0;     // drive mem_ready high while no access is open
  int            wcnt = 0;

  always @(negedge clock) begin
    if (mem_req === 1'b1) begin
      if (ready_delay >= 0 && wcnt == ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rd_val ^ mem_addr;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 64'hBADB_ADBA_DBAD_BADB;
      end
      wcnt++;
    end else begin
      mem_ready = spur;
      mem_rdata = 64'hFFFF_0000_FFFF_0000;
      wcnt = 0;
    end
  end

  // ---------------- transaction-level model ----------------
  // phase: 0 = nothing outstanding, 1 = access open at the memory,
  //        2 = completion being reported to the owner.
  bit            m_valid = 1'b0;
  int            m_phase;
  bit            m_last_dm;
  bit            m_owner_dm;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_waited;
  logic [DW-1:0] e_if_rdata, e_dm_rdata;
  bit            e_if_ack, e_dm_ack, e_mem_req, e_err;

  task automatic model_complete(input bit abort);
    e_mem_req = 1'b0;
    if (m_owner_dm) e_dm_ack = 1'b1; else e_if_ack = 1'b1;
    if (abort) begin
      e_err = 1'b1;
      if (m_owner_dm) e_dm_rdata = '0; else e_if_rdata = '0;
    end else if (!m_we) begin
      if (m_owner_dm) e_dm_rdata = mem_rdata; else e_if_rdata = mem_rdata;
    end
    m_phase = 2;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1'b1; m_phase = 0; m_last_dm = 1'b1; m_owner_dm = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_waited = 0;
      e_if_rdata = '0; e_dm_rdata = '0;
      e_if_ack = 1'b0; e_dm_ack = 1'b0; e_mem_req = 1'b0; e_err = 1'b0;
    end else if (m_valid) begin
      e_if_ack = 1'b0; e_dm_ack = 1'b0; e_err = 1'b0;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        m_waited++;
        if (mem_ready) model_complete(1'b0);
`ifdef LEGV8_ARB_TIMEOUT_EN
        else if (m_waited == TO) model_complete(1'b1);
`endif
      end else if (if_req || dm_req) begin
        if (if_req && dm_req) m_owner_dm = !m_last_dm;
        else                  m_owner_dm = dm_req;
        m_last_dm = m_owner_dm;
        m_we      = m_owner_dm ? dm_we : 1'b0;
        m_addr    = m_owner_dm ? dm_addr : if_addr;
        m_wdata   = m_owner_dm ? dm_wdata : '0;
        m_waited  = 0;
        e_mem_req = 1'b1;
        m_phase   = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int            mreq_cycles = 0;
  logic          snap_we;
  logic [AW-1:0] snap_addr;
  logic [DW-1:0] snap_wdata;

  always @(posedge clock) begin
    #1;
    if (m_valid) begin
      chk("if_ack",   {63'd0, if_ack},  {63'd0, e_if_ack});
      chk("dm_ack",   {63'd0, dm_ack},  {63'd0, e_dm_ack});
      chk("mem_req",  {63'd0, mem_req}, {63'd0, e_mem_req});
      chk("err",      {63'd0, err},     {63'd0, e_err});
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("dm_rdata", dm_rdata, e_dm_rdata);
      if (e_mem_req) begin
        chk("mem_we",    {63'd0, mem_we}, {63'd0, m_we});
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
    if (mem_req === 1'b1) begin
      mreq_cycles++;
      snap_we = mem_we; snap_addr = mem_addr; snap_wdata = mem_wdata;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  // Issues one request in an IDLE cycle and waits for its ack. lat counts
  // negedges from issue to the one where ack is seen; ack in the third cycle
  // of the transaction (counting the request cycle as the first) gives lat=2.
  task automatic txn(input bit dm, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                     output int lat, output logic e);
    bit got;
    @(negedge clock);
    if (dm) begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; end
    else    begin if_req = 1'b1; if_addr = a; end
    lat = 0; rd = '0; e = 1'b0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      lat++;
      if (dm ? dm_ack : if_ack) begin
        got = 1'b1;
        rd  = dm ? dm_rdata : if_rdata;
        e   = err;
      end
    end
    if (!got) chk("ack_wait_expired", 64'd0, 64'd1);
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          e;
  int            lat;
  logic [DW-1:0] held;
  string         order;

  initial begin
    // 1: reset, then an IF read with mem_ready in the first BUSY cycle
    do_reset(2);
    chk("rst_mem_req",  {63'd0, mem_req}, 64'd0);
    chk("rst_if_ack",   {63'd0, if_ack},  64'd0);
    chk("rst_dm_ack",   {63'd0, dm_ack},  64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    chk("rst_err",      {63'd0, err},     64'd0);
    ready_delay = 0; mreq_cycles = 0;
    txn(1'b0, 1'b0, 64'h0, 64'h0, rd, lat, e);
    chk("t1_if_rdata",   rd, 64'h0000_0000_9100_0000);
    chk("t1_latency",    64'(lat), 64'd2);
    chk("t1_mreq_cycles", 64'(mreq_cycles), 64'd1);

    // 2: DM load to set dm_rdata, then a store that must not disturb it
    spur = 1'b1;
    txn(1'b1, 1'b0, 64'h48, 64'h0, rd, lat, e);
    chk("t2_load_rdata", rd, 64'h0000_0000_9100_0048);
    held = dm_rdata;
    txn(1'b1, 1'b1, 64'h40, 64'hDEAD_BEEF, rd, lat, e);
    chk("t2_mem_we",    {63'd0, snap_we}, 64'd1);
    chk("t2_mem_addr",  snap_addr, 64'h40);
    chk("t2_mem_wdata", snap_wdata, 64'hDEAD_BEEF);
    chk("t2_latency",   64'(lat), 64'd2);
    chk("t2_dm_rdata_held", dm_rdata, held);

    // 3: continuous contention after reset -> IF,DM,IF,DM
    do_reset(1);
    order = "";
    @(negedge clock);
    if_req = 1'b1; if_addr = 64'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h300;
    for (int i = 0; i < 100 && order.len() < 4; i++) begin
      @(negedge clock);
      if (if_ack) order = {order, "I"};
      if (dm_ack) order = {order, "D"};
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("t3_grant_count", 64'(order.len()), 64'd4);
    chk("t3_grant_order", {32'd0, order == "IDID" ? 32'd1 : 32'd0}, 64'd1);
    chk("t3_dm_rdata", dm_rdata, 64'h0000_0000_9100_0300);
    spur = 1'b0;

    // 4: memory answers after 5 wait cycles
    ready_delay = 5; mreq_cycles = 0;
    txn(1'b0, 1'b0, 64'h100, 64'h0, rd, lat, e);
    chk("t4_latency",     64'(lat), 64'd7);
    chk("t4_mreq_cycles", 64'(mreq_cycles), 64'd6);
    chk("t4_if_rdata",    rd, 64'h0000_0000_9100_0100);
    @(negedge clock);
    chk("t4_single_pulse", {63'd0, if_ack}, 64'd0);

    // 5: reset during BUSY drops the access
    ready_delay = -1;
    @(negedge clock);
    if_req = 1'b1; if_addr = 64'h10;
    repeat (2) @(negedge clock);
    reset = 1'b1; if_req = 1'b0;
    @(posedge clock); #1;
    chk("t5_mem_req_dropped", {63'd0, mem_req}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("t5_no_ack", {62'd0, if_ack, dm_ack}, 64'd0);
    end
    ready_delay = 0;
    txn(1'b0, 1'b0, 64'h8, 64'h0, rd, lat, e);
    chk("t5_after_rdata",   rd, 64'h0000_0000_9100_0008);
    chk("t5_after_latency", 64'(lat), 64'd2);

`ifdef LEGV8_ARB_TIMEOUT_EN
    // 6: memory never answers -> abort after TO BUSY cycles
    txn(1'b1, 1'b0, 64'h58, 64'h0, rd, lat, e);
    chk("t6_pre_rdata", rd, 64'h0000_0000_9100_0058);
    ready_delay = -1;
    txn(1'b1, 1'b0, 64'h60, 64'h0, rd, lat, e);
    chk("t6_latency", 64'(lat), 64'(TO + 1));
    chk("t6_err",     {63'd0, e}, 64'd1);
    chk("t6_rdata",   rd, 64'd0);
    @(negedge clock);
    chk("t6_err_clear", {63'd0, err}, 64'd0);
    ready_delay = 0;
`endif

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
